muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide unit for the core's execute stage: the multi-cycle counterpart to the single-cycle integer ALU, using the same operand/result naming (A, B, O) and a 3-bit operation select equal to the instruction's funct3. It accepts one operation per start pulse, computes it over a fixed number of cycles with a shift-add multiplier or a restoring divider, and returns the result with a one-cycle done pulse. The pipeline controller stalls on busy.

---
 rtl/muldiv_unit.sv | 169 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiplier and restoring divider
// sharing one accumulator pair, fixed XLEN+1 cycle latency from start to done.
module muldiv_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      operation,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] O
);

  localparam int unsigned CW = $clog2(XLEN);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      op_q, op_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] addend_q, addend_d;
  logic [XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic            a_neg_q, a_neg_d;
  logic            b_neg_q, b_neg_d;
  logic            b_zero_q, b_zero_d;
  logic [XLEN-1:0] o_q, o_d;
  logic            done_q, done_d;

  logic            a_sgn, b_sgn;
  logic [XLEN-1:0] a_mag, b_mag;
  logic [XLEN:0]   shifted, diff, sum;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0] quo, rem;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    a_d      = a_q;
    addend_d = addend_q;
    acc_d    = acc_q;
    lo_d     = lo_q;
    a_neg_d  = a_neg_q;
    b_neg_d  = b_neg_q;
    b_zero_d = b_zero_q;
    o_d      = o_q;
    done_d   = 1'b0;
    a_sgn    = 1'b0;
    b_sgn    = 1'b0;
    a_mag    = '0;
    b_mag    = '0;
    shifted  = '0;
    diff     = '0;
    sum      = '0;
    prod     = '0;
    quo      = '0;
    rem      = '0;

    case (state_q)
      IDLE: begin
        if (start) begin
          // Signed rs1: MULH, MULHSU, DIV, REM. Signed rs2: MULH, DIV, REM.
          a_sgn    = (operation == 3'b001) || (operation == 3'b010) ||
                     (operation == 3'b100) || (operation == 3'b110);
          b_sgn    = (operation == 3'b001) || (operation == 3'b100) ||
                     (operation == 3'b110);
          a_neg_d  = a_sgn & A[XLEN-1];
          b_neg_d  = b_sgn & B[XLEN-1];
          a_mag    = a_neg_d ? -A : A;
          b_mag    = b_neg_d ? -B : B;
          op_d     = operation;
          a_d      = A;
          b_zero_d = (B == '0);
          acc_d    = '0;
          cnt_d    = '0;
          if (operation[2]) begin
            addend_d = b_mag;
            lo_d     = a_mag;
          end else begin
            addend_d = a_mag;
            lo_d     = b_mag;
          end
          state_d = RUN;
        end
      end

      RUN: begin
        if (op_q[2]) begin
          shifted = {acc_q, lo_q[XLEN-1]};
          diff    = shifted - {1'b0, addend_q};
          if (!diff[XLEN]) begin
            acc_d = diff[XLEN-1:0];
            lo_d  = {lo_q[XLEN-2:0], 1'b1};
          end else begin
            acc_d = shifted[XLEN-1:0];
            lo_d  = {lo_q[XLEN-2:0], 1'b0};
          end
        end else begin
          sum = {1'b0, acc_q} + (lo_q[0] ? {1'b0, addend_q} : '0);
          {acc_d, lo_d} = {sum, lo_q[XLEN-1:1]};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(XLEN - 1)) state_d = FIX;
      end

      FIX: begin
        if (!op_q[2]) begin
          prod = {acc_q, lo_q};
          if (a_neg_q ^ b_neg_q) prod = -prod;
          o_d = (op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        end else begin
          // Overflow (MIN / -1) falls out of the magnitude path: quotient 2^(XLEN-1), remainder 0.
          quo = (a_neg_q ^ b_neg_q) ? -lo_q : lo_q;
          rem = a_neg_q ? -acc_q : acc_q;
          if (b_zero_q) o_d = op_q[1] ? a_q : '1;
          else          o_d = op_q[1] ? rem : quo;
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      a_q      <= '0;
      addend_q <= '0;
      acc_q    <= '0;
      lo_q     <= '0;
      a_neg_q  <= 1'b0;
      b_neg_q  <= 1'b0;
      b_zero_q <= 1'b0;
      o_q      <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      a_q      <= a_d;
      addend_q <= addend_d;
      acc_q    <= acc_d;
      lo_q     <= lo_d;
      a_neg_q  <= a_neg_d;
      b_neg_q  <= b_neg_d;
      b_zero_q <= b_zero_d;
      o_q      <= o_d;
      done_q   <= done_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign O    = o_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed vector table, handshake/reset sequences and random
// operations, all scored by a cycle-level model of busy/done/O.
module tb_muldiv_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  operation;
  logic [31:0] A, B;
  logic        busy, done;
  logic [31:0] O;

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .operation(operation),
    .A(A), .B(B), .busy(busy), .done(done), .O(O)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned cyc   = 0;

  logic [31:0] drv_exp;
  logic [31:0] sb_q[$];
  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  logic [31:0] m_o    = '0;
  int          m_cnt  = 0;

  function automatic void check(string nm, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, got, exp);
    end
  endfunction

  function automatic logic [31:0] ref_model(logic [2:0] op, logic [31:0] a, logic [31:0] b);
    int          sa, sb;
    longint      p;
    logic [63:0] u;
    sa = a;
    sb = b;
    u  = {32'b0, a} * {32'b0, b};
    case (op)
      3'd0: return u[31:0];
      3'd1: begin p = longint'(sa) * longint'(sb); return p[63:32]; end
      3'd2: begin p = longint'(sa) * longint'({32'b0, b}); return p[63:32]; end
      3'd3: return u[63:32];
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return sa / sb;
      end
      3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return sa % sb;
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  // Model: acceptance only when idle; done exactly 33 edges after the accepting edge.
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_busy = 1'b0;
      m_done = 1'b0;
      m_o    = '0;
      m_cnt  = 0;
      sb_q.delete();
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_busy = 1'b0;
          m_done = 1'b1;
          if (sb_q.size() > 0) m_o = sb_q.pop_front();
        end
      end else if (start) begin
        m_busy = 1'b1;
        m_cnt  = 33;
        sb_q.push_back(drv_exp);
      end
    end
    #1;
    check("busy", {31'b0, busy}, {31'b0, m_busy});
    check("done", {31'b0, done}, {31'b0, m_done});
    check("O", O, m_o);
  end

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp);
    @(negedge clk);
    start = 1'b1; operation = op; A = a; B = b; drv_exp = exp;
    @(negedge clk);
    start = 1'b0;
    repeat (33) @(negedge clk);
  endtask

  vec_t        vecs[16];
  logic [31:0] bnd[5];

  initial begin
    vecs[0]  = '{3'd0, 32'd7,          32'd6,          32'd42};
    vecs[1]  = '{3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0000};
    vecs[2]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE};
    vecs[3]  = '{3'd2, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFF};
    vecs[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD};
    vecs[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF};
    vecs[6]  = '{3'd5, 32'd100,        32'd7,          32'd14};
    vecs[7]  = '{3'd7, 32'd100,        32'd7,          32'd2};
    vecs[8]  = '{3'd4, 32'h0000_1234,  32'd0,          32'hFFFF_FFFF};
    vecs[9]  = '{3'd5, 32'h0000_1234,  32'd0,          32'hFFFF_FFFF};
    vecs[10] = '{3'd6, 32'h0000_1234,  32'd0,          32'h0000_1234};
    vecs[11] = '{3'd7, 32'h0000_1234,  32'd0,          32'h0000_1234};
    vecs[12] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000};
    vecs[13] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0000_0000};
    vecs[14] = '{3'd1, 32'h8000_0000,  32'h8000_0000,  32'h4000_0000};
    vecs[15] = '{3'd4, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD};
    bnd[0] = 32'h0000_0000; bnd[1] = 32'h0000_0001; bnd[2] = 32'h7FFF_FFFF;
    bnd[3] = 32'h8000_0000; bnd[4] = 32'hFFFF_FFFF;

    rst = 1'b1; start = 1'b0; operation = '0; A = '0; B = '0; drv_exp = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);

    // Second start mid-run with new operands must be ignored.
    @(negedge clk);
    start = 1'b1; operation = 3'd0; A = 32'd11; B = 32'd13; drv_exp = 32'd143;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    start = 1'b1; operation = 3'd5; A = 32'd99; B = 32'd3; drv_exp = 32'hDEAD_BEEF;
    @(negedge clk);
    start = 1'b0;
    repeat (30) @(negedge clk);

    // start held high: one acceptance every 34 cycles.
    @(negedge clk);
    start = 1'b1; operation = 3'd0; A = 32'd3; B = 32'd5; drv_exp = 32'd15;
    repeat (34 * 3) @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);

    // Reset during a DIV discards the result; a following MUL completes normally.
    @(negedge clk);
    start = 1'b1; operation = 3'd4; A = 32'd100; B = 32'd7; drv_exp = 32'd14;
    @(negedge clk);
    start = 1'b0;
    repeat (13) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    issue(3'd0, 32'd9, 32'd9, 32'd81);

    for (int i = 0; i < 800; i++) begin
      logic [2:0]  op;
      logic [31:0] a, b;
      op = 3'($urandom_range(0, 7));
      a  = ($urandom_range(0, 3) == 0) ? bnd[$urandom_range(0, 4)] : $urandom;
      b  = ($urandom_range(0, 3) == 0) ? bnd[$urandom_range(0, 4)] : $urandom;
      issue(op, a, b, ref_model(op, a, b));
    end

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
